mac_row_dual: RTL and testbench
===============================

Name: mac_row_dual

Overview:
- Parametrised next-generation systolic MAC row: COL lanes chained west-to-east, each lane a signed BW x BW multiply-accumulate.
- Supports weight-stationary (WS) mode, where partial sums flow north-to-south, and output-stationary (OS) mode, where weights flow north-to-south and sums accumulate locally.
- Adds a weight-clear instruction, a drain state machine that captures OS results with a handshake, and a mode lock while busy.
- Instanced once per array row, between the L0/activation feeder (west) and the OFIFO (south).

Parameters:
BW, 4, activation/weight width (signed two's complement)
PSUM_BW, 16, partial-sum/accumulator width
COL, 8, number of MAC lanes

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
mode  input  1  0=WS, 1=OS; applied only when busy=0
in_w  input  BW  activation from west
inst_w  input  2  [1]=execute, [0]=kernel load; 2'b11=weight clear
in_n  input  PSUM_BW*COL  WS: psum per lane; OS: weight in low BW bits of each slice
drain  input  1  OS drain request, single-cycle pulse
out_s  output  PSUM_BW*COL  WS: psum per lane; OS: sign-extended weight forwarded south
valid  output  COL  per-lane "out_s updated this cycle"
os_out_row  output  PSUM_BW*COL  captured OS accumulators
os_valid  output  1  one-cycle strobe: os_out_row is new
busy  output  1  drain in progress

Behaviour:
- Reset (reset=0, async): all outputs 0; lane weights, loaded flags, accumulators, activation/instruction pipeline cleared; FSM=IDLE; mode_q=0. Reset mid-drain aborts the drain: no os_valid, accumulators zeroed.
- Skew: lane 0 consumes in_w/inst_w directly. Lane c+1 consumes lane c's registered activation/instruction. An op issued at cycle t is processed by lane c at t+c; its result appears at t+c+1.
- mode_q <= mode on every edge where busy=0; held while busy=1. All lanes use mode_q.
- Load (2'b01), both modes: a lane with loaded=0 captures the activation into w_c, sets loaded=1, and forwards the instruction east with bit0 cleared. A lane with loaded=1 forwards activation and instruction unchanged. Loads w0..w(COL-1) issued on consecutive cycles land in lanes 0..COL-1.
- Clear (2'b11): each lane sets loaded=0 and w_c=0 as the op passes, forwards it unchanged, and does not assert valid.
- WS execute (2'b10): out_s_c <= in_n_c + sext(a_c*w_c), modulo 2^PSUM_BW (wraps, no saturation); valid[c]=1 that cycle. Non-execute cycles: out_s_c holds, valid[c]=0.
- OS execute: b_c = in_n_c[BW-1:0] (signed); acc_c <= acc_c + sext(a_c*b_c), modulo 2^PSUM_BW; out_s_c <= sext(b_c); valid[c]=1. Weights are not latched in OS; load and clear still act on w_c/loaded.
- Drain FSM (OS only):
  - IDLE: drain=1 with mode_q=1 -> WAIT; counter=COL-1. Drain with mode_q=0 is ignored.
  - WAIT: counter decrements; at 0 -> CAPTURE.
  - CAPTURE: os_out_row <= all acc_c; os_valid=1 for this one cycle; all acc_c cleared -> IDLE.
  - busy=1 in WAIT and CAPTURE.
- Drain boundary conditions:
  - Drain while busy: ignored.
  - Execute reaching lane c in the CAPTURE cycle: acc_c <= product only; the captured value excludes that product.
  - Executes issued after drain are the sender's responsibility. They accumulate normally and are captured only if they reach their lane before CAPTURE.
- os_out_row holds between captures; os_valid=0 otherwise.
- valid and out_s are also driven for executes issued while busy.

Test Plan:
- WS basic, COL=8: load w_c=c-3 on cycles 0..7; execute a=2 at cycle 10 with in_n slices=10 -> out_s lane0=4 ... lane7=18; valid[c] high only at cycle 11+c.
- WS wrap: w=7, a=7, in_n=16'h7FFF -> out_s=16'h8030. Negative case w=-8, a=7, in_n=0 -> 16'hFFC8.
- Reload: after the first load, issue 2'b11 then loads of all 1s -> lane c computes in_n+a; the clear produces no valid pulses.
- OS accumulate/drain: mode=1; 4 executes a=3, b=-2 on all lanes; drain 1 cycle after the last issue -> busy high 8 cycles; os_valid one cycle; every os_out_row slice=16'hFFE8; accumulators read 0 on the next drain.
- Mode lock/ignore: toggle mode during busy -> mode_q is unchanged until busy drops; drain while busy and drain in WS mode -> no os_valid.
- Reset mid-drain: reset low during WAIT -> busy=0, os_valid never pulses, the next drain captures all zeros.

Source files
------------

// File: rtl/mac_row_dual_if.sv
// Row-level bus between the west feeder, the north psum/weight source and the south OFIFO.
// Master side drives operands and drain requests; slave side (the MAC row) returns results.
interface mac_row_dual_if #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int COL     = 8
);
  logic                   mode;
  logic [BW-1:0]          in_w;
  logic [1:0]             inst_w;
  logic [PSUM_BW*COL-1:0] in_n;
  logic                   drain;
  logic [PSUM_BW*COL-1:0] out_s;
  logic [COL-1:0]         valid;
  logic [PSUM_BW*COL-1:0] os_out_row;
  logic                   os_valid;
  logic                   busy;

  modport master (
    output mode, in_w, inst_w, in_n, drain,
    input  out_s, valid, os_out_row, os_valid, busy
  );

  modport slave (
    input  mode, in_w, inst_w, in_n, drain,
    output out_s, valid, os_out_row, os_valid, busy
  );
endinterface

// File: rtl/mac_row_dual.sv
// Systolic MAC row: COL signed BWxBW lanes chained west-to-east, WS (psum south) or OS (local accumulate).
// Weight clear, OS drain FSM with a one-cycle capture strobe, and mode lock while a drain is busy.
module mac_row_dual #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int COL     = 8
) (
  input  logic          clk,
  input  logic          reset,
  mac_row_dual_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   mode_q;
  logic                   busy_q;
  logic                   os_valid_q;
  logic [PSUM_BW*COL-1:0] os_row_q;
  logic [PSUM_BW*COL-1:0] out_s_q;
  logic [COL-1:0]         valid_q;
  logic [COL-1:0]         loaded_q;
  logic [BW-1:0]          act_q  [COL];
  logic [1:0]             inst_q [COL];
  logic [BW-1:0]          w_q    [COL];
  logic [PSUM_BW-1:0]     acc_q  [COL];
  logic [BW-1:0]          a_in   [COL];
  logic [1:0]             i_in   [COL];
  logic                   capture;

  function automatic logic [PSUM_BW-1:0] sext(input logic [BW-1:0] x);
    return {{(PSUM_BW-BW){x[BW-1]}}, x};
  endfunction

  // Product of sign-extended operands is already the wrapped PSUM_BW result.
  function automatic logic [PSUM_BW-1:0] smul(input logic [BW-1:0] x, input logic [BW-1:0] y);
    return sext(x) * sext(y);
  endfunction

  assign capture = (state == CAPTURE);

  always_comb begin
    a_in[0] = bus.in_w;
    i_in[0] = bus.inst_w;
    for (int c = 1; c < COL; c++) begin
      a_in[c] = act_q[c-1];
      i_in[c] = inst_q[c-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_s_q  <= '0;
      valid_q  <= '0;
      loaded_q <= '0;
      for (int c = 0; c < COL; c++) begin
        act_q[c]  <= '0;
        inst_q[c] <= '0;
        w_q[c]    <= '0;
        acc_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < COL; c++) begin
        act_q[c]   <= a_in[c];
        inst_q[c]  <= i_in[c];
        valid_q[c] <= 1'b0;
        if (capture) acc_q[c] <= '0;
        case (i_in[c])
          // A load is consumed by the first empty lane; downstream lanes see a no-op.
          2'b01: if (!loaded_q[c]) begin
            w_q[c]      <= a_in[c];
            loaded_q[c] <= 1'b1;
            inst_q[c]   <= 2'b00;
          end
          2'b11: begin
            w_q[c]      <= '0;
            loaded_q[c] <= 1'b0;
          end
          2'b10: begin
            valid_q[c] <= 1'b1;
            if (mode_q) begin
              acc_q[c] <= (capture ? '0 : acc_q[c]) + smul(a_in[c], bus.in_n[c*PSUM_BW +: BW]);
              out_s_q[c*PSUM_BW +: PSUM_BW] <= sext(bus.in_n[c*PSUM_BW +: BW]);
            end else begin
              out_s_q[c*PSUM_BW +: PSUM_BW] <= bus.in_n[c*PSUM_BW +: PSUM_BW] + smul(a_in[c], w_q[c]);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Drain waits COL cycles in total so the last lane sees ops issued just before the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      os_valid_q <= 1'b0;
      os_row_q   <= '0;
    end else begin
      os_valid_q <= 1'b0;
      if (!busy_q) mode_q <= bus.mode;
      case (state)
        IDLE: if (bus.drain && mode_q) begin
          state  <= WAIT;
          cnt    <= CW'(COL - 1);
          busy_q <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1) || cnt == '0) state <= CAPTURE;
        end
        CAPTURE: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          os_valid_q <= 1'b1;
          for (int c = 0; c < COL; c++) os_row_q[c*PSUM_BW +: PSUM_BW] <= acc_q[c];
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_s      = out_s_q;
  assign bus.valid      = valid_q;
  assign bus.os_out_row = os_row_q;
  assign bus.os_valid   = os_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mac_row_dual.sv
// Directed and random op sequences for mac_row_dual, checked per cycle against an op-walking row model.
module tb_mac_row_dual;
  localparam int BW = 4, PW = 16, COL = 8, NMAX = 64;
  localparam int WW = PW * COL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_row_dual_if #(.BW(BW), .PSUM_BW(PW), .COL(COL)) bus ();
  mac_row_dual #(.BW(BW), .PSUM_BW(PW), .COL(COL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Stimulus for one phase, indexed by issue cycle.
  logic [1:0]    p_inst  [NMAX];
  logic [BW-1:0] p_a     [NMAX];
  logic [PW-1:0] p_inn   [NMAX][COL];
  logic          p_drain [NMAX];
  logic          p_mode  [NMAX];
  int            p_len;

  // Reference row state.
  int            m_w      [COL];
  bit            m_loaded [COL];
  int            m_acc    [COL];
  logic [PW-1:0] m_out    [COL];
  logic [PW-1:0] m_row    [COL];
  logic [1:0]    f_inst   [NMAX];
  bit            m_mq, m_busy;
  int            m_td, m_cap;
  int            busy_cnt, osv_cnt;

  function automatic int sx(input logic [BW-1:0] v);
    return v[BW-1] ? int'(v) - (1 << BW) : int'(v);
  endfunction

  function automatic logic [PW-1:0] lane(input int c);
    return bus.out_s[c*PW +: PW];
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < COL; c++) begin
      m_w[c] = 0; m_loaded[c] = 1'b0; m_acc[c] = 0; m_out[c] = '0; m_row[c] = '0;
    end
    m_mq = 1'b0; m_busy = 1'b0;
  endtask

  task automatic ph_new(input int len, input logic md);
    p_len = len;
    for (int t = 0; t < NMAX; t++) begin
      p_inst[t] = 2'b00; p_a[t] = BW'($urandom); p_drain[t] = 1'b0; p_mode[t] = md;
      for (int c = 0; c < COL; c++) p_inn[t][c] = PW'($urandom);
    end
  endtask

  task automatic fill_inn(input logic [PW-1:0] v);
    for (int t = 0; t < NMAX; t++)
      for (int c = 0; c < COL; c++) p_inn[t][c] = v;
  endtask

  // Op t reaches lane c in cycle t+c; a drain accepted at cycle d is busy d..d+COL-1 and captures at d+COL.
  task automatic model_cycle(input int T, output logic [COL-1:0] ev, output logic osv);
    int t, a, b;
    logic [1:0] ins;
    ev = '0;
    osv = (T == m_cap);
    if (osv) for (int c = 0; c < COL; c++) begin m_row[c] = PW'(m_acc[c]); m_acc[c] = 0; end
    for (int c = 0; c < COL; c++) begin
      t = T - c;
      if (t >= 0) begin
        ins = (c == 0) ? p_inst[t] : f_inst[t];
        a = sx(p_a[t]);
        case (ins)
          2'b01: if (!m_loaded[c]) begin m_w[c] = a; m_loaded[c] = 1'b1; ins = 2'b00; end
          2'b11: begin m_w[c] = 0; m_loaded[c] = 1'b0; end
          2'b10: begin
            ev[c] = 1'b1;
            if (m_mq) begin
              b = sx(p_inn[T][c][BW-1:0]);
              m_acc[c] = m_acc[c] + a * b;
              m_out[c] = PW'(b);
            end else begin
              m_out[c] = PW'(int'(p_inn[T][c]) + a * m_w[c]);
            end
          end
          default: ;
        endcase
        f_inst[t] = ins;
      end
    end
    if (!m_busy && p_drain[T] && m_mq) begin m_td = T; m_cap = T + COL; end
    if (!m_busy) m_mq = p_mode[T];
    m_busy = (T >= m_td) && (T < m_td + COL);
  endtask

  task automatic run_phase();
    logic [COL-1:0] ev;
    logic osv;
    logic [WW-1:0] row;
    m_td = -100; m_cap = -100; busy_cnt = 0; osv_cnt = 0;
    for (int T = 0; T < p_len; T++) begin
      bus.in_w = p_a[T]; bus.inst_w = p_inst[T]; bus.drain = p_drain[T]; bus.mode = p_mode[T];
      for (int c = 0; c < COL; c++) bus.in_n[c*PW +: PW] = p_inn[T][c];
      model_cycle(T, ev, osv);
      @(posedge clk); #1;
      for (int c = 0; c < COL; c++) begin
        chk($sformatf("out_s[%0d] T=%0d", c, T), lane(c), m_out[c]);
        row[c*PW +: PW] = m_row[c];
      end
      chk($sformatf("valid T=%0d", T), bus.valid, ev);
      chk($sformatf("busy T=%0d", T), bus.busy, m_busy);
      chk($sformatf("os_valid T=%0d", T), bus.os_valid, osv);
      chk($sformatf("os_out_row T=%0d", T), bus.os_out_row, row);
      busy_cnt += int'(bus.busy);
      osv_cnt  += int'(bus.os_valid);
    end
    bus.inst_w = 2'b00; bus.drain = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_busy", bus.busy, '0);
    chk("rst_os_valid", bus.os_valid, '0);
    chk("rst_out_s", bus.out_s, '0);
    chk("rst_valid", bus.valid, '0);
    chk("rst_os_out_row", bus.os_out_row, '0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_os_valid", bus.os_valid, '0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    bit mb;
    bus.mode = 1'b0; bus.in_w = '0; bus.inst_w = '0; bus.in_n = '0; bus.drain = 1'b0;
    #3;
    do_reset();

    // WS basic: w_c = c-3, execute a=2 against psum 10.
    ph_new(30, 1'b0);
    for (int k = 0; k < COL; k++) begin p_inst[k] = 2'b01; p_a[k] = BW'(k - 3); end
    p_inst[10] = 2'b10; p_a[10] = 4'd2;
    fill_inn(16'd10);
    run_phase();
    chk("ws_basic_lane0", lane(0), 16'd4);
    chk("ws_basic_lane7", lane(7), 16'd18);

    // Reload with weights of 1 after a clear, then random executes.
    ph_new(40, 1'b0);
    p_inst[0] = 2'b11;
    for (int k = 1; k <= COL; k++) begin p_inst[k] = 2'b01; p_a[k] = 4'd1; end
    for (int k = 20; k < 28; k++) p_inst[k] = 2'b10;
    run_phase();

    // WS wrap: 7*7 + 0x7FFF.
    ph_new(30, 1'b0);
    p_inst[0] = 2'b11;
    for (int k = 1; k <= COL; k++) begin p_inst[k] = 2'b01; p_a[k] = 4'd7; end
    p_inst[12] = 2'b10; p_a[12] = 4'd7;
    fill_inn(16'h7FFF);
    run_phase();
    chk("ws_wrap_lane4", lane(4), 16'h8030);

    // WS negative: -8*7 + 0.
    ph_new(30, 1'b0);
    p_inst[0] = 2'b11;
    for (int k = 1; k <= COL; k++) begin p_inst[k] = 2'b01; p_a[k] = 4'h8; end
    p_inst[12] = 2'b10; p_a[12] = 4'd7;
    fill_inn(16'h0000);
    run_phase();
    chk("ws_neg_lane2", lane(2), 16'hFFC8);

    // OS: four executes of 3*(-2), drain one cycle after the last issue.
    ph_new(30, 1'b1);
    for (int k = 2; k < 6; k++) begin p_inst[k] = 2'b10; p_a[k] = 4'd3; end
    fill_inn(16'h000E);
    p_drain[6] = 1'b1;
    run_phase();
    chk("os_busy_cycles", busy_cnt, 8);
    chk("os_valid_pulses", osv_cnt, 1);
    for (int c = 0; c < COL; c++)
      chk($sformatf("os_row_lane%0d", c), bus.os_out_row[c*PW +: PW], 16'hFFE8);

    // A second drain sees cleared accumulators.
    ph_new(20, 1'b1);
    p_drain[2] = 1'b1;
    run_phase();
    chk("os_redrain_pulses", osv_cnt, 1);
    chk("os_redrain_row", bus.os_out_row, '0);

    // Mode toggled while busy, drain while busy, executes during busy, then a drain in WS.
    ph_new(45, 1'b1);
    for (int k = 1; k < 7; k++) p_inst[k] = 2'b10;
    p_drain[7] = 1'b1;
    for (int k = 9; k < 45; k++) p_mode[k] = 1'b0;
    p_drain[10] = 1'b1;
    p_inst[10] = 2'b10; p_inst[11] = 2'b10; p_inst[25] = 2'b10;
    p_drain[28] = 1'b1;
    run_phase();
    chk("lock_valid_pulses", osv_cnt, 1);
    chk("lock_busy_cycles", busy_cnt, 8);

    // Random mixes of loads, clears, executes, drains and mode changes.
    repeat (6) begin
      ph_new(48, 1'($urandom_range(0, 1)));
      for (int t = 0; t < 48; t++) begin
        if (t % 8 == 0) mb = 1'($urandom_range(0, 1));
        p_mode[t] = mb;
        if (t < 48 - COL - 1) p_inst[t] = 2'($urandom_range(0, 3));
        if (t < 48 - COL - 3) p_drain[t] = ($urandom_range(0, 5) == 0);
      end
      run_phase();
    end

    // Reset while the drain is waiting.
    ph_new(8, 1'b1);
    p_inst[1] = 2'b10; p_inst[2] = 2'b10;
    p_drain[4] = 1'b1;
    run_phase();
    chk("pre_reset_busy", bus.busy, 1'b1);
    do_reset();
    ph_new(16, 1'b1);
    p_drain[2] = 1'b1;
    run_phase();
    chk("post_reset_pulses", osv_cnt, 1);
    chk("post_reset_row", bus.os_out_row, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
